stopwatch_lap_bcd: RTL and testbench

//   Next-generation stopwatch core: a parametrised millisecond prescaler drives a

---
 rtl/stopwatch_lap_bcd.sv | 263 ++++++++++++++++++++++++++
 tb/tb_stopwatch_lap_bcd.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_bcd.sv
// Stopwatch core with a millisecond prescaler and a cascaded BCD time counter
// (hh:mm:ss.mmm). It counts up or down, loads a preset, and raises a sticky
// done flag when a count-down reaches zero. A first-word-fall-through lap FIFO
// keeps snapshots of the time. All flops change on the falling edge of NEclk.
// Digit packing everywhere is {h1,h0,min1,min0,s1,s0,ms2,ms1,ms0}, so ms0
// occupies bits [3:0] and h1 occupies bits [35:32].
module stopwatch_lap_bcd #(
   parameter int TICK_DIV  = 50000,
   parameter int LAP_DEPTH = 8,
   parameter int HR_MAX    = 99
) (
   input  logic                           NEclk,
   input  logic                           Nreset,
   input  logic                           Enable,
   input  logic                           Clear,
   input  logic                           Mode,
   input  logic                           Load,
   input  logic [35:0]                    preset_bcd,
   input  logic                           lap_push,
   input  logic                           lap_pop,
   output logic [35:0]                    lap_data,
   output logic                           lap_valid,
   output logic                           lap_full,
   output logic [$clog2(LAP_DEPTH+1)-1:0] lap_level,
   output logic                           lap_ovf,
   output logic                           done,
   output logic                           tick_ms,
   output logic [3:0]                     bcd_h_1,
   output logic [3:0]                     bcd_h_0,
   output logic [3:0]                     bcd_min_1,
   output logic [3:0]                     bcd_min_0,
   output logic [3:0]                     bcd_s_1,
   output logic [3:0]                     bcd_s_0,
   output logic [3:0]                     bcd_ms_2,
   output logic [3:0]                     bcd_ms_1,
   output logic [3:0]                     bcd_ms_0
);

   // A single-cycle divider still needs a one-bit counter that sits at zero.
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = $clog2(LAP_DEPTH);
   localparam int LW = $clog2(LAP_DEPTH + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0]    HR_MAX_1   = 4'(HR_MAX / 10);
   localparam logic [3:0]    HR_MAX_0   = 4'(HR_MAX % 10);
   localparam logic [7:0]    HR_MAX_V   = 8'(HR_MAX);
   localparam logic [LW-1:0] LEVEL_FULL = LW'(LAP_DEPTH);

   // Wrap value of the seven digits below the hours, index 0 = ms0 .. 6 = min1.
   localparam logic [6:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9, 4'd9};

   // ------------------------------------------------------------------
   // Time state
   // ------------------------------------------------------------------
   logic [8:0][3:0] dig_q, dig_d;
   logic [8:0][3:0] step_val;
   logic [PW-1:0]   presc_q, presc_d;
   logic            done_q, done_d;

   logic            preset_ok;
   logic            load_ok;
   logic            all_zero;
   logic            next_zero;
   logic            hold_zero;
   logic [7:0]      preset_hr;

   assign tick_ms   = Enable && (presc_q == PRESC_LAST);
   assign all_zero  = (dig_q == '0);
   assign next_zero = (step_val == '0);
   // A count-down parked at zero stays there; ticks keep pulsing but do nothing.
   assign hold_zero = Mode && all_zero;
   assign load_ok   = Load && preset_ok;
   assign preset_hr = ({4'd0, preset_bcd[35:32]} * 8'd10) + {4'd0, preset_bcd[31:28]};

   // Preset is accepted only if every field is a legal value for its position.
   always_comb begin
      preset_ok = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (preset_bcd[i*4 +: 4] > 4'd9) begin
            preset_ok = 1'b0;
         end
      end
      if (preset_bcd[19:16] > 4'd5) begin
         preset_ok = 1'b0;
      end
      if (preset_bcd[27:24] > 4'd5) begin
         preset_ok = 1'b0;
      end
      if (preset_hr > HR_MAX_V) begin
         preset_ok = 1'b0;
      end
   end

   // One step of the BCD cascade: increment with carry or decrement with borrow.
   always_comb begin : g_step
      logic carry;
      logic at_end;
      step_val = dig_q;
      carry    = 1'b1;
      at_end   = 1'b0;
      for (int i = 0; i < 7; i++) begin
         at_end = Mode ? (dig_q[i] == 4'd0) : (dig_q[i] == DIG_MAX[i]);
         if (carry) begin
            if (at_end) begin
               step_val[i] = Mode ? DIG_MAX[i] : 4'd0;
            end else if (Mode) begin
               step_val[i] = dig_q[i] - 4'd1;
            end else begin
               step_val[i] = dig_q[i] + 4'd1;
            end
         end
         carry = carry & at_end;
      end
      // Hours run as a two-digit BCD pair bounded by HR_MAX rather than 99.
      if (carry) begin
         if (Mode) begin
            if ((dig_q[8] == 4'd0) && (dig_q[7] == 4'd0)) begin
               step_val[8] = HR_MAX_1;
               step_val[7] = HR_MAX_0;
            end else if (dig_q[7] == 4'd0) begin
               step_val[8] = dig_q[8] - 4'd1;
               step_val[7] = 4'd9;
            end else begin
               step_val[7] = dig_q[7] - 4'd1;
            end
         end else begin
            if ((dig_q[8] == HR_MAX_1) && (dig_q[7] == HR_MAX_0)) begin
               step_val[8] = 4'd0;
               step_val[7] = 4'd0;
            end else if (dig_q[7] == 4'd9) begin
               step_val[8] = dig_q[8] + 4'd1;
               step_val[7] = 4'd0;
            end else begin
               step_val[7] = dig_q[7] + 4'd1;
            end
         end
      end
   end

   // Next time state with priority Clear > legal Load > tick.
   always_comb begin
      dig_d   = dig_q;
      presc_d = presc_q;
      done_d  = done_q;
      if (Clear) begin
         dig_d   = '0;
         presc_d = '0;
         done_d  = 1'b0;
      end else if (load_ok) begin
         dig_d   = preset_bcd;
         presc_d = '0;
         done_d  = 1'b0;
      end else if (Enable) begin
         presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
         if (tick_ms) begin
            if (hold_zero) begin
               done_d = 1'b1;
            end else begin
               dig_d = step_val;
               if (Mode && next_zero) begin
                  done_d = 1'b1;
               end
            end
         end
      end
   end

   // Time registers.
   always_ff @(negedge NEclk or negedge Nreset) begin
      if (!Nreset) begin
         dig_q   <= '0;
         presc_q <= '0;
         done_q  <= 1'b0;
      end else begin
         dig_q   <= dig_d;
         presc_q <= presc_d;
         done_q  <= done_d;
      end
   end

   assign done      = done_q;
   assign bcd_ms_0  = dig_q[0];
   assign bcd_ms_1  = dig_q[1];
   assign bcd_ms_2  = dig_q[2];
   assign bcd_s_0   = dig_q[3];
   assign bcd_s_1   = dig_q[4];
   assign bcd_min_0 = dig_q[5];
   assign bcd_min_1 = dig_q[6];
   assign bcd_h_0   = dig_q[7];
   assign bcd_h_1   = dig_q[8];

   // ------------------------------------------------------------------
   // Lap FIFO
   // ------------------------------------------------------------------
   logic [35:0]   lap_mem [LAP_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ovf_q, ovf_d;
   logic          fifo_full;
   logic          fifo_valid;
   logic          do_push;
   logic          do_pop;
   logic          push_drop;

   assign fifo_full  = (level_q == LEVEL_FULL);
   assign fifo_valid = (level_q != '0);
   // A pop on a full FIFO frees the slot the simultaneous push needs.
   assign do_pop     = lap_pop && fifo_valid && !Clear;
   assign do_push    = lap_push && !Clear && (!fifo_full || do_pop);
   assign push_drop  = lap_push && !Clear && fifo_full && !lap_pop;

   // Pointer, level and overflow bookkeeping; Clear discards a same-edge push.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (Clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         wr_ptr_d = wr_ptr_q + AW'(do_push);
         rd_ptr_d = rd_ptr_q + AW'(do_pop);
         level_d  = level_q + LW'(do_push) - LW'(do_pop);
         ovf_d    = ovf_q | push_drop;
      end
   end

   // FIFO control registers.
   always_ff @(negedge NEclk or negedge Nreset) begin
      if (!Nreset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Snapshot storage; the pushed value is the time shown before this edge.
   always_ff @(negedge NEclk) begin
      if (do_push) begin
         lap_mem[wr_ptr_q] <= dig_q;
      end
   end

   // Oldest entry is presented combinationally so it is usable the moment
   // lap_valid rises; an empty FIFO shows zero.
   assign lap_data  = fifo_valid ? lap_mem[rd_ptr_q] : '0;
   assign lap_valid = fifo_valid;
   assign lap_full  = fifo_full;
   assign lap_level = level_q;
   assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_bcd.sv
// Directed bench for stopwatch_lap_bcd with a small prescaler, a four-entry
// lap FIFO and a one-hour limit. Expected times and lap entries are queued
// when stimulus is applied and popped when the result is checked.
module tb_stopwatch_lap_bcd;

   localparam int TICK_DIV  = 2;
   localparam int LAP_DEPTH = 4;
   localparam int HR_MAX    = 1;

   logic        NEclk      = 1'b1;
   logic        Nreset     = 1'b1;
   logic        Enable     = 1'b0;
   logic        Clear      = 1'b0;
   logic        Mode       = 1'b0;
   logic        Load       = 1'b0;
   logic [35:0] preset_bcd = '0;
   logic        lap_push   = 1'b0;
   logic        lap_pop    = 1'b0;

   logic [35:0] lap_data;
   logic        lap_valid;
   logic        lap_full;
   logic [2:0]  lap_level;
   logic        lap_ovf;
   logic        done;
   logic        tick_ms;
   logic [3:0]  bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0;
   logic [3:0]  bcd_ms_2, bcd_ms_1, bcd_ms_0;
   logic [35:0] live;

   int n_assert = 0;
   int n_fail   = 0;

   logic [35:0] exp_q[$];
   logic [35:0] lap_model[$];
   logic [35:0] snaps[5];

   stopwatch_lap_bcd #(
      .TICK_DIV (TICK_DIV),
      .LAP_DEPTH(LAP_DEPTH),
      .HR_MAX   (HR_MAX)
   ) dut (
      .NEclk     (NEclk),
      .Nreset    (Nreset),
      .Enable    (Enable),
      .Clear     (Clear),
      .Mode      (Mode),
      .Load      (Load),
      .preset_bcd(preset_bcd),
      .lap_push  (lap_push),
      .lap_pop   (lap_pop),
      .lap_data  (lap_data),
      .lap_valid (lap_valid),
      .lap_full  (lap_full),
      .lap_level (lap_level),
      .lap_ovf   (lap_ovf),
      .done      (done),
      .tick_ms   (tick_ms),
      .bcd_h_1   (bcd_h_1),
      .bcd_h_0   (bcd_h_0),
      .bcd_min_1 (bcd_min_1),
      .bcd_min_0 (bcd_min_0),
      .bcd_s_1   (bcd_s_1),
      .bcd_s_0   (bcd_s_0),
      .bcd_ms_2  (bcd_ms_2),
      .bcd_ms_1  (bcd_ms_1),
      .bcd_ms_0  (bcd_ms_0)
   );

   assign live = {bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0,
                  bcd_ms_2, bcd_ms_1, bcd_ms_0};

   always #5 NEclk = ~NEclk;

   function automatic logic [35:0] t(int h, int m, int s, int ms);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
              4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
   endfunction

   task automatic chk(string tag, logic [35:0] obs, logic [35:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Compare live time against the oldest queued expectation.
   task automatic chk_time(string tag);
      logic [35:0] expv;
      expv = exp_q.pop_front();
      chk(tag, live, expv);
   endtask

   // Compare FIFO head against the oldest modelled snapshot and consume it.
   task automatic chk_lap_pop(string tag);
      logic [35:0] expv;
      expv = lap_model.pop_front();
      chk(tag, lap_data, expv);
   endtask

   // Each cycle: active falling edge, then sample/drive on the rising edge.
   task automatic clk_n(int n);
      repeat (n) begin
         @(negedge NEclk);
         @(posedge NEclk);
      end
   endtask

   task automatic do_load(logic [35:0] v);
      preset_bcd = v;
      Load       = 1'b1;
      clk_n(1);
      Load       = 1'b0;
   endtask

   initial begin
      snaps[0] = t(0, 12, 34, 567);
      snaps[1] = t(1, 0, 0, 1);
      snaps[2] = t(0, 59, 59, 999);
      snaps[3] = t(0, 0, 0, 9);
      snaps[4] = t(1, 23, 45, 678);

      // Reset state
      #1 Nreset = 1'b0;
      #2;
      chk("rst_time", live, 36'd0);
      chk("rst_flags", 36'({lap_valid, lap_full, lap_ovf, done, tick_ms}), 36'd0);
      chk("rst_level", 36'(lap_level), 36'd0);
      chk("rst_lapdata", lap_data, 36'd0);
      @(posedge NEclk);
      Nreset = 1'b1;

      // Up count across the minute boundary
      exp_q.push_back(t(0, 0, 59, 998));
      do_load(t(0, 0, 59, 998));
      chk_time("t1_load");
      Enable = 1'b1;
      clk_n(1);
      chk("t1_tick_hi", 36'(tick_ms), 36'd1);
      exp_q.push_back(t(0, 0, 59, 999));
      clk_n(1);
      chk_time("t1_tick1");
      chk("t1_tick_lo", 36'(tick_ms), 36'd0);
      exp_q.push_back(t(0, 1, 0, 0));
      clk_n(2);
      chk_time("t1_minute");
      Enable = 1'b0;

      // Wrap after HR_MAX:59:59.999
      do_load(t(1, 59, 59, 999));
      Enable = 1'b1;
      exp_q.push_back(36'd0);
      clk_n(2);
      chk_time("t2_wrap");
      chk("t2_done", 36'(done), 36'd0);
      Enable = 1'b0;

      // Count down to zero, done held, then resume upward
      do_load(t(0, 0, 1, 2));
      Mode   = 1'b1;
      Enable = 1'b1;
      exp_q.push_back(t(0, 0, 0, 999));
      clk_n(6);
      chk_time("t3_borrow");
      exp_q.push_back(t(0, 0, 0, 1));
      clk_n(1996);
      chk_time("t3_one");
      chk("t3_done_early", 36'(done), 36'd0);
      exp_q.push_back(36'd0);
      clk_n(2);
      chk_time("t3_zero");
      chk("t3_done", 36'(done), 36'd1);
      clk_n(1);
      chk("t3_tick_at_zero", 36'(tick_ms), 36'd1);
      exp_q.push_back(36'd0);
      clk_n(9);
      chk_time("t3_hold");
      chk("t3_done_held", 36'(done), 36'd1);
      Mode = 1'b0;
      exp_q.push_back(t(0, 0, 0, 1));
      clk_n(2);
      chk_time("t3_resume_up");
      chk("t3_done_sticky", 36'(done), 36'd1);
      Enable = 1'b0;
      exp_q.push_back(t(0, 0, 0, 5));
      do_load(t(0, 0, 0, 5));
      chk_time("t3_reload");
      chk("t3_done_cleared", 36'(done), 36'd0);

      // Lap FIFO: fill, overflow, drain in order
      for (int k = 0; k < 4; k++) begin
         do_load(snaps[k]);
         lap_push = 1'b1;
         clk_n(1);
         lap_push = 1'b0;
         lap_model.push_back(snaps[k]);
      end
      chk("t4_full4", 36'({lap_full, lap_ovf}), 36'b10);
      do_load(snaps[4]);
      lap_push = 1'b1;
      clk_n(1);
      lap_push = 1'b0;
      chk("t4_level", 36'(lap_level), 36'd4);
      chk("t4_full_ovf", 36'({lap_full, lap_ovf}), 36'b11);
      for (int k = 0; k < 4; k++) begin
         chk_lap_pop($sformatf("t4_pop%0d", k));
         lap_pop = 1'b1;
         clk_n(1);
         lap_pop = 1'b0;
      end
      chk("t4_empty", 36'({lap_valid, lap_level}), 36'd0);
      chk("t4_empty_data", lap_data, 36'd0);
      lap_pop = 1'b1;
      clk_n(1);
      lap_pop = 1'b0;
      chk("t4_pop_empty", 36'(lap_level), 36'd0);
      lap_push = 1'b1;
      lap_pop  = 1'b1;
      clk_n(1);
      lap_push = 1'b0;
      lap_pop  = 1'b0;
      lap_model.push_back(snaps[4]);
      chk("t4_pushpop_empty_lvl", 36'(lap_level), 36'd1);
      chk("t4_pushpop_empty_data", lap_data, lap_model[0]);
      chk("t4_ovf_sticky", 36'(lap_ovf), 36'd1);
      for (int j = 1; j < 4; j++) begin
         do_load(t(0, 0, 0, j));
         lap_push = 1'b1;
         clk_n(1);
         lap_push = 1'b0;
         lap_model.push_back(t(0, 0, 0, j));
      end
      do_load(t(0, 0, 0, 7));
      lap_push = 1'b1;
      lap_pop  = 1'b1;
      clk_n(1);
      lap_push = 1'b0;
      lap_pop  = 1'b0;
      void'(lap_model.pop_front());
      lap_model.push_back(t(0, 0, 0, 7));
      chk("t4_pushpop_full_lvl", 36'(lap_level), 36'd4);
      chk("t4_pushpop_full_data", lap_data, lap_model[0]);

      // Illegal loads leave time untouched; Clear beats a same-edge push
      exp_q.push_back(t(0, 0, 0, 7));
      do_load({4'h0, 4'hA, 28'h0});
      chk_time("t5_bad_hour_digit");
      exp_q.push_back(t(0, 0, 0, 7));
      do_load({4'h0, 4'h0, 4'h6, 4'h0, 20'h0});
      chk_time("t5_bad_min1");
      exp_q.push_back(t(0, 0, 0, 7));
      do_load(t(2, 0, 0, 0));
      chk_time("t5_bad_hr_max");
      Clear    = 1'b1;
      lap_push = 1'b1;
      clk_n(1);
      Clear    = 1'b0;
      lap_push = 1'b0;
      lap_model.delete();
      exp_q.push_back(36'd0);
      chk_time("t5_clear_time");
      chk("t5_clear_fifo", 36'({lap_valid, lap_full, lap_ovf, lap_level}), 36'd0);

      // Asynchronous reset in the middle of a prescale period
      do_load(t(0, 0, 0, 2));
      Mode   = 1'b1;
      Enable = 1'b1;
      clk_n(4);
      chk("t6_done_pre", 36'(done), 36'd1);
      Mode     = 1'b0;
      lap_push = 1'b1;
      clk_n(1);
      lap_push = 1'b0;
      exp_q.push_back(t(0, 0, 0, 1));
      clk_n(2);
      chk_time("t6_pre_time");
      chk("t6_pre_flags", 36'({done, tick_ms, lap_level}), 36'({1'b1, 1'b1, 3'd1}));
      #2 Nreset = 1'b0;
      #1;
      chk("t6_rst_time", live, 36'd0);
      chk("t6_rst_flags", 36'({lap_valid, lap_full, lap_ovf, done, tick_ms, lap_level}), 36'd0);
      chk("t6_rst_lapdata", lap_data, 36'd0);
      @(posedge NEclk);
      Nreset = 1'b1;
      Enable = 1'b0;
      clk_n(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
